sc_frame_controller: RTL
========================

// Module: sc_frame_controller
// PURPOSE
//  Sequences the Schmidl-Cox receive path: consumes the sample stream plus per-sample detect flag from the
//  detector, discards samples while searching, captures packet_length samples after each detection, segments
//  them into RFNoC packets (tlast/tlength/teob), then enforces a holdoff before re-arming. Sits between the
//  detector output and the noc_shell out stream; config comes from the block's ctrlport registers.
// PARAMETERS
//  DATA_W   32    sample width (sc16 I/Q)
//  LEN_W    16    width of packet_length, spp, holdoff, o_tlength
//  CNT_W    16    width of frame_count status counter
// PORTS
//  clk            in   1      sole clock (axis_data_clk domain)
//  reset_n        in   1      asynchronous, active-low reset
//  cfg_enable     in   1      1 = arm search; 0 = go idle after current frame
//  cfg_pkt_len    in   LEN_W  samples per captured frame (0 treated as 1)
//  cfg_spp        in   LEN_W  samples per RFNoC packet (0 treated as 2**LEN_W-1)
//  cfg_holdoff    in   LEN_W  samples dropped after a frame before re-arm
//  i_tdata        in   DATA_W input sample
//  i_tdetect      in   1      detector flag, qualified by i_tvalid
//  i_tvalid       in   1      input valid
//  i_tready       out  1      input ready
//  o_tdata        out  DATA_W captured sample
//  o_tlast        out  1      last sample of RFNoC packet
//  o_tlength      out  LEN_W  sample count of current RFNoC packet, stable for whole packet
//  o_teob         out  1      last packet of frame (asserted for all beats of that packet)
//  o_tvalid       out  1      output valid
//  o_tready       in   1      output ready
//  frame_count    out  CNT_W  completed frames, wraps at 2**CNT_W
//  busy           out  1      1 in CAPTURE or HOLDOFF
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; all outputs 0 (i_tready=0, o_*=0, frame_count=0, busy=0).
//  States: IDLE -> SEARCH when cfg_enable=1. SEARCH: i_tready=1, samples dropped; beat with i_tdetect=1 is
//   first frame sample -> latch cfg_pkt_len/spp/holdoff, enter CAPTURE. CAPTURE: forward samples; after
//   pkt_len-th output beat accepted -> HOLDOFF (holdoff>0) else SEARCH/IDLE per cfg_enable; frame_count++.
//   HOLDOFF: i_tready=1, drop exactly holdoff beats, then SEARCH (cfg_enable=1) or IDLE.
//   SEARCH with cfg_enable=0 -> IDLE next cycle; CAPTURE/HOLDOFF always complete regardless of cfg_enable.
//  Datapath: one registered output stage, latency 1 cycle; i_tready in CAPTURE = !o_tvalid | o_tready.
//   No beat lost or duplicated under arbitrary o_tready backpressure; o_* held stable while o_tvalid&!o_tready.
//  Segmentation: remaining r counts down from pkt_len; packet length = min(spp, r) at packet start;
//   o_tlast on final beat of each packet; o_teob on every beat of final packet; pkt_len multiple of spp
//   gives no runt packet.
//  i_tdetect ignored outside SEARCH (no re-trigger inside a frame or holdoff).
//  Config changes mid-frame take effect at next detection only.
//  Counters saturate nowhere except frame_count (wraps).
// CONFIGURATION
//  `SC_FRAME_TIMESTAMP_EN defined: adds free-running 64-bit sample counter (increments per accepted input
//   beat) and output o_ttimestamp[63:0] = counter value of the detect sample, constant over the whole frame;
//   reset to 0. Undefined: no counter, no o_ttimestamp port.
// STRUCTURE
//  sc_frame_pkg: state enum sc_frame_state_t {IDLE,SEARCH,CAPTURE,HOLDOFF}, LEN_W/CNT_W defaults,
//   function eff_len() applying the 0-substitution rules.
//  One sub-module sc_pkt_segmenter: owns remaining/packet counters, produces tlast/tlength/teob.
// TESTING
//  pkt_len=8, spp=4, holdoff=0, detect at beat 5 -> beats 5..12 out, tlength=4, tlast on 8 and 12, teob on 9..12.
//  pkt_len=10, spp=4 -> packets 4,4,2; tlength 4,4,2; teob only on last 2 beats; frame_count=1.
//  holdoff=6, detects at beats 0 and 3 inside frame/holdoff -> ignored; next detect honoured only after 6 drops.
//  Random o_tready (50%) over 1000-sample frame -> output equals input slice exactly, no stalls beyond backpressure.
//  reset_n pulsed low mid-CAPTURE -> o_tvalid=0 immediately, IDLE, frame_count=0; clean re-capture after release.
//  cfg_enable dropped mid-frame -> frame completes, holdoff completes, then IDLE, i_tready=0.

Source files
------------

// File: rtl/sc_frame_pkg.sv
// Shared types and helpers for the Schmidl-Cox frame controller.
// Holds the state encoding, default widths and the zero-substitution rule.
package sc_frame_pkg;

    localparam int SC_DATA_W = 32;
    localparam int SC_LEN_W  = 16;
    localparam int SC_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        CAPTURE,
        HOLDOFF
    } sc_frame_state_t;

    // A zero length config field is replaced by zero_val.
    function automatic logic [SC_LEN_W-1:0] eff_len(
        input logic [SC_LEN_W-1:0] v,
        input logic [SC_LEN_W-1:0] zero_val
    );
        return (v == '0) ? zero_val : v;
    endfunction

endpackage

// File: rtl/sc_frame_if.sv
// Sample-in / packet-out stream bundle of the frame controller.
// SC_FRAME_TIMESTAMP_EN adds the o_ttimestamp sideband.
interface sc_frame_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    logic [DATA_W-1:0] i_tdata;
    logic              i_tdetect;
    logic              i_tvalid;
    logic              i_tready;
    logic [DATA_W-1:0] o_tdata;
    logic              o_tlast;
    logic [LEN_W-1:0]  o_tlength;
    logic              o_teob;
    logic              o_tvalid;
    logic              o_tready;
`ifdef SC_FRAME_TIMESTAMP_EN
    logic [63:0]       o_ttimestamp;

    modport master (
        input  i_tdata, i_tdetect, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tlength,
        output o_teob, o_tvalid, o_ttimestamp
    );

    modport slave (
        output i_tdata, i_tdetect, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tlength,
        input  o_teob, o_tvalid, o_ttimestamp
    );
`else
    modport master (
        input  i_tdata, i_tdetect, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tlength,
        output o_teob, o_tvalid
    );

    modport slave (
        output i_tdata, i_tdetect, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tlength,
        input  o_teob, o_tvalid
    );
`endif
endinterface

// File: rtl/sc_pkt_segmenter.sv
// Splits a captured frame into RFNoC packets; produces per-beat
// tlast/tlength/teob for the beat being loaded into the output stage.
module sc_pkt_segmenter
    import sc_frame_pkg::*;
#(
    parameter int LEN_W = SC_LEN_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    input  logic [LEN_W-1:0] spp,
    output logic             beat_last,
    output logic [LEN_W-1:0] beat_len,
    output logic             beat_eob
);

    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] left_q, left_d;
    logic [LEN_W-1:0] plen_q, plen_d;
    logic [LEN_W-1:0] spp_q, spp_d;
    logic             eob_q, eob_d;

    logic [LEN_W-1:0] rem_c;
    logic [LEN_W-1:0] spp_c;
    logic [LEN_W-1:0] seg_len;
    logic [LEN_W-1:0] left_c;
    logic             new_pkt;

    always_comb begin
        rem_c     = start ? len : rem_q;
        spp_c     = start ? spp : spp_q;
        new_pkt   = start || (left_q == '0);
        seg_len   = (spp_c < rem_c) ? spp_c : rem_c;
        left_c    = new_pkt ? seg_len : left_q;
        beat_len  = new_pkt ? seg_len : plen_q;
        beat_eob  = new_pkt ? (seg_len == rem_c) : eob_q;
        beat_last = (left_c == LEN_W'(1));

        rem_d  = rem_q;
        left_d = left_q;
        plen_d = plen_q;
        spp_d  = spp_q;
        eob_d  = eob_q;
        if (load) begin
            rem_d  = rem_c - LEN_W'(1);
            left_d = left_c - LEN_W'(1);
            plen_d = beat_len;
            spp_d  = spp_c;
            eob_d  = beat_eob;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q  <= '0;
            left_q <= '0;
            plen_q <= '0;
            spp_q  <= '0;
            eob_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            left_q <= left_d;
            plen_q <= plen_d;
            spp_q  <= spp_d;
            eob_q  <= eob_d;
        end
    end

endmodule

// File: rtl/sc_frame_controller.sv
// Schmidl-Cox receive sequencer: search, capture+segment, holdoff.
// Define SC_FRAME_TIMESTAMP_EN for the 64-bit detect timestamp.
module sc_frame_controller
    import sc_frame_pkg::*;
#(
    parameter int DATA_W = SC_DATA_W,
    parameter int LEN_W  = SC_LEN_W,
    parameter int CNT_W  = SC_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_enable,
    input  logic [LEN_W-1:0] cfg_pkt_len,
    input  logic [LEN_W-1:0] cfg_spp,
    input  logic [LEN_W-1:0] cfg_holdoff,
    sc_frame_if.master       bus,
    output logic [CNT_W-1:0] frame_count,
    output logic             busy
);

    sc_frame_state_t   state_q, state_d;
    logic [DATA_W-1:0] o_tdata_q, o_tdata_d;
    logic              o_tlast_q, o_tlast_d;
    logic [LEN_W-1:0]  o_tlength_q, o_tlength_d;
    logic              o_teob_q, o_teob_d;
    logic              o_tvalid_q, o_tvalid_d;
    logic [LEN_W-1:0]  in_rem_q, in_rem_d;
    logic [LEN_W-1:0]  hold_cfg_q, hold_cfg_d;
    logic [LEN_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]  frame_count_q, frame_count_d;
    logic              busy_q, busy_d;

    logic             in_ready;
    logic             in_fire;
    logic             out_fire;
    logic             detect;
    logic             seg_load;
    logic             frame_done;
    logic [LEN_W-1:0] eff_pkt_len;
    logic [LEN_W-1:0] eff_spp;
    logic             seg_last;
    logic [LEN_W-1:0] seg_len;
    logic             seg_eob;

    assign out_fire    = o_tvalid_q && bus.o_tready;
    assign eff_pkt_len = eff_len(cfg_pkt_len, LEN_W'(1));
    assign eff_spp     = eff_len(cfg_spp, '1);

    // Capture stops pulling input once the whole frame is inside.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            SEARCH, HOLDOFF: in_ready = 1'b1;
            CAPTURE: in_ready = (!o_tvalid_q || bus.o_tready) && (in_rem_q != '0);
            default: in_ready = 1'b0;
        endcase
    end

    assign in_fire    = bus.i_tvalid && in_ready;
    assign detect     = (state_q == SEARCH) && cfg_enable && in_fire && bus.i_tdetect;
    assign seg_load   = detect || ((state_q == CAPTURE) && in_fire);
    assign frame_done = (state_q == CAPTURE) && out_fire && o_tlast_q && o_teob_q;

    sc_pkt_segmenter #(.LEN_W(LEN_W)) u_seg (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (detect),
        .load      (seg_load),
        .len       (eff_pkt_len),
        .spp       (eff_spp),
        .beat_last (seg_last),
        .beat_len  (seg_len),
        .beat_eob  (seg_eob)
    );

    always_comb begin
        state_d       = state_q;
        o_tdata_d     = o_tdata_q;
        o_tlast_d     = o_tlast_q;
        o_tlength_d   = o_tlength_q;
        o_teob_d      = o_teob_q;
        o_tvalid_d    = o_tvalid_q;
        in_rem_d      = in_rem_q;
        hold_cfg_d    = hold_cfg_q;
        hold_d        = hold_q;
        frame_count_d = frame_count_q;

        if (seg_load) begin
            o_tdata_d   = bus.i_tdata;
            o_tlast_d   = seg_last;
            o_tlength_d = seg_len;
            o_teob_d    = seg_eob;
            o_tvalid_d  = 1'b1;
        end else if (out_fire) begin
            o_tvalid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (cfg_enable) state_d = SEARCH;
            end
            SEARCH: begin
                if (!cfg_enable) begin
                    state_d = IDLE;
                end else if (detect) begin
                    state_d    = CAPTURE;
                    in_rem_d   = eff_pkt_len - LEN_W'(1);
                    hold_cfg_d = cfg_holdoff;
                end
            end
            CAPTURE: begin
                if (in_fire) in_rem_d = in_rem_q - LEN_W'(1);
                if (frame_done) begin
                    frame_count_d = frame_count_q + CNT_W'(1);
                    if (hold_cfg_q != '0) begin
                        state_d = HOLDOFF;
                        hold_d  = hold_cfg_q;
                    end else begin
                        state_d = cfg_enable ? SEARCH : IDLE;
                    end
                end
            end
            HOLDOFF: begin
                if (in_fire) begin
                    hold_d = hold_q - LEN_W'(1);
                    if (hold_q == LEN_W'(1)) state_d = cfg_enable ? SEARCH : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CAPTURE) || (state_d == HOLDOFF);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            o_tdata_q     <= '0;
            o_tlast_q     <= 1'b0;
            o_tlength_q   <= '0;
            o_teob_q      <= 1'b0;
            o_tvalid_q    <= 1'b0;
            in_rem_q      <= '0;
            hold_cfg_q    <= '0;
            hold_q        <= '0;
            frame_count_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            o_tdata_q     <= o_tdata_d;
            o_tlast_q     <= o_tlast_d;
            o_tlength_q   <= o_tlength_d;
            o_teob_q      <= o_teob_d;
            o_tvalid_q    <= o_tvalid_d;
            in_rem_q      <= in_rem_d;
            hold_cfg_q    <= hold_cfg_d;
            hold_q        <= hold_d;
            frame_count_q <= frame_count_d;
            busy_q        <= busy_d;
        end
    end

`ifdef SC_FRAME_TIMESTAMP_EN
    logic [63:0] ts_cnt_q, ts_cnt_d;
    logic [63:0] ts_q, ts_d;

    // Timestamp is the index of the detect beat in the accepted stream.
    always_comb begin
        ts_cnt_d = in_fire ? ts_cnt_q + 64'd1 : ts_cnt_q;
        ts_d     = detect ? ts_cnt_q : ts_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_q     <= ts_d;
        end
    end

    assign bus.o_ttimestamp = ts_q;
`endif

    assign bus.i_tready  = in_ready;
    assign bus.o_tdata   = o_tdata_q;
    assign bus.o_tlast   = o_tlast_q;
    assign bus.o_tlength = o_tlength_q;
    assign bus.o_teob    = o_teob_q;
    assign bus.o_tvalid  = o_tvalid_q;
    assign frame_count   = frame_count_q;
    assign busy          = busy_q;

endmodule
